// File: rtl/multi_button_debouncer_if.sv
// Button-bank bundle: raw pins and counter clear in, debounced levels, event pulses
// and packed per-channel press counters out.
interface multi_button_debouncer_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 8
);
  logic [N_CH-1:0]       button;
  logic                  clr_count;
  logic [N_CH-1:0]       btn_level;
  logic [N_CH-1:0]       press_pulse;
  logic [N_CH-1:0]       release_pulse;
  logic [N_CH-1:0]       long_pulse;
  logic [N_CH*CNT_W-1:0] press_count;

  modport master (
    output button, clr_count,
    input  btn_level, press_pulse, release_pulse, long_pulse, press_count
  );

  modport slave (
    input  button, clr_count,
    output btn_level, press_pulse, release_pulse, long_pulse, press_count
  );
endinterface

// File: rtl/multi_button_debouncer.sv
// N-channel push-button debouncer: 2-flop synchroniser, stable-level filter, press/release
// and long-press pulses, and a wrapping press counter per channel.
module multi_button_debouncer #(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter int unsigned CNT_W           = 8
) (
  input logic                      clk,
  input logic                      rst,
  multi_button_debouncer_if.slave  bus
);
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StArmHi, StHeld, StArmLo} state_e;

  logic [N_CH-1:0] r_sync1, r_sync2;
  logic [N_CH-1:0] w_level, w_press, w_release, w_long;
  logic [N_CH*CNT_W-1:0] w_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.button;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_e            r_state, w_state_d;
    logic [DB_W-1:0]   r_db_cnt, w_db_cnt_d, w_db_inc;
    logic [HOLD_W-1:0] r_hold, w_hold_d;
    logic [CNT_W-1:0]  r_count, w_count_d;
    logic              r_long_done, w_long_done_d;
    logic              r_press, w_press_d;
    logic              r_release, w_release_d;
    logic              r_long, w_long_d;
    logic              w_s, w_is_high;

    assign w_s       = r_sync2[g];
    assign w_is_high = (r_state == StHeld) || (r_state == StArmLo);
    // r_db_cnt = consecutive differing samples already seen; the current one makes w_db_inc.
    assign w_db_inc  = r_db_cnt + DB_W'(1);

    always_comb begin
      w_state_d   = r_state;
      w_db_cnt_d  = r_db_cnt;
      w_press_d   = 1'b0;
      w_release_d = 1'b0;
      unique case (r_state)
        StIdle, StArmHi: begin
          if (!w_s) begin
            w_state_d  = StIdle;
            w_db_cnt_d = '0;
          end else if (w_db_inc == DB_W'(DEBOUNCE_CYCLES)) begin
            w_state_d  = StHeld;
            w_db_cnt_d = '0;
            w_press_d  = 1'b1;
          end else begin
            w_state_d  = StArmHi;
            w_db_cnt_d = w_db_inc;
          end
        end
        StHeld, StArmLo: begin
          if (w_s) begin
            w_state_d  = StHeld;
            w_db_cnt_d = '0;
          end else if (w_db_inc == DB_W'(DEBOUNCE_CYCLES)) begin
            w_state_d   = StIdle;
            w_db_cnt_d  = '0;
            w_release_d = 1'b1;
          end else begin
            w_state_d  = StArmLo;
            w_db_cnt_d = w_db_inc;
          end
        end
        default: begin
          w_state_d  = StIdle;
          w_db_cnt_d = '0;
        end
      endcase
    end

    // Hold timing keeps running through ARM_LO so a short low glitch does not restart it.
    always_comb begin
      w_hold_d      = r_hold;
      w_long_d      = 1'b0;
      w_long_done_d = r_long_done;
      if (w_is_high && (r_hold != HOLD_W'(LONG_CYCLES))) begin
        w_hold_d = r_hold + HOLD_W'(1);
        if ((w_hold_d == HOLD_W'(LONG_CYCLES)) && !r_long_done) begin
          w_long_d      = 1'b1;
          w_long_done_d = 1'b1;
        end
      end
      if (w_press_d) w_hold_d = '0;
      if (w_release_d) w_long_done_d = 1'b0;
    end

    // Counter follows the registered press pulse so a clear seen alongside it keeps the press.
    always_comb begin
      w_count_d = r_count;
      if (r_press) begin
        w_count_d = bus.clr_count ? CNT_W'(1) : r_count + CNT_W'(1);
      end else if (bus.clr_count) begin
        w_count_d = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state     <= StIdle;
        r_db_cnt    <= '0;
        r_hold      <= '0;
        r_count     <= '0;
        r_long_done <= 1'b0;
        r_press     <= 1'b0;
        r_release   <= 1'b0;
        r_long      <= 1'b0;
      end else begin
        r_state     <= w_state_d;
        r_db_cnt    <= w_db_cnt_d;
        r_hold      <= w_hold_d;
        r_count     <= w_count_d;
        r_long_done <= w_long_done_d;
        r_press     <= w_press_d;
        r_release   <= w_release_d;
        r_long      <= w_long_d;
      end
    end

    assign w_level[g]                 = w_is_high;
    assign w_press[g]                 = r_press;
    assign w_release[g]               = r_release;
    assign w_long[g]                  = r_long;
    assign w_count[g*CNT_W +: CNT_W]  = r_count;
  end

  assign bus.btn_level     = w_level;
  assign bus.press_pulse   = w_press;
  assign bus.release_pulse = w_release;
  assign bus.long_pulse    = w_long;
  assign bus.press_count   = w_count;
endmodule

// File: doc/multi_button_debouncer.md
Name: multi_button_debouncer

Overview:
Parametrised N-channel push-button debouncer for the Spartan-6 board designs. It replaces the single-button debouncer. Each channel has:
- a 2-flop input synchroniser
- a stable-level filter
- one-cycle press and release event pulses
- a long-press event
- a wrapping press counter for LED display.

It sits between raw board pins and user logic or the LED bank.

Parameters:
N_CH, 4, number of independent button channels (1..16)
DEBOUNCE_CYCLES, 50000, consecutive clocks the synchronised input must differ from the stable level before the level flips (>=1)
LONG_CYCLES, 50000000, clocks the stable level must stay high before long_pulse fires (>=1)
CNT_W, 8, width of each per-channel press counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
button  input  N_CH  raw asynchronous button pins, 1 = pressed
clr_count  input  1  synchronous clear of all press counters
btn_level  output  N_CH  debounced stable level per channel
press_pulse  output  N_CH  1-cycle pulse on debounced 0->1
release_pulse  output  N_CH  1-cycle pulse on debounced 1->0
long_pulse  output  N_CH  1-cycle pulse once per press after LONG_CYCLES held
press_count  output  N_CH*CNT_W  channel i count at bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset (rst=1 at a clk edge):
  - synchroniser flops, btn_level, all pulses, internal counters and press_count go to 0.
  - Reset mid-debounce or mid-hold discards progress. No pulse is emitted on the reset edge.
- Synchroniser: s[i] = button[i] delayed by 2 flops. Only s[i] is used downstream.
- Per-channel FSM, states:
  - IDLE (level 0)
  - ARM_HI (level 0, s=1 counting)
  - HELD (level 1)
  - ARM_LO (level 1, s=0 counting)
- Transitions:
  - IDLE -> ARM_HI when s=1; db_cnt=1.
  - ARM_HI: if s=0, go to IDLE and clear db_cnt. Else if db_cnt==DEBOUNCE_CYCLES, go to HELD; btn_level<=1; press_pulse=1 for one cycle. Else db_cnt++.
  - HELD -> ARM_LO when s=0; db_cnt=1.
  - ARM_LO: if s=1, go to HELD and clear db_cnt. Else if db_cnt==DEBOUNCE_CYCLES, go to IDLE; btn_level<=0; release_pulse=1. Else db_cnt++.
  - The hold counter keeps counting in ARM_LO, so a glitch low does not restart long-press timing.
- Latency: a clean edge on button, first sampled at edge k, changes btn_level and raises the pulse after edge k+1+DEBOUNCE_CYCLES. The pulse is registered and coincident with the btn_level change.
- Any bounce shorter than DEBOUNCE_CYCLES consecutive synchronised clocks produces no level change and no pulse.
- Long press:
  - hold_cnt clears on press_pulse and increments each cycle while in HELD/ARM_LO.
  - When hold_cnt reaches LONG_CYCLES, long_pulse=1 for one cycle, then a per-press flag blocks further long pulses.
  - The flag clears on release. hold_cnt saturates and does not wrap.
- Press counter:
  - +1 on each press_pulse, modulo 2^CNT_W (255 -> 0 for CNT_W=8).
  - clr_count alone sets the counter to 0.
  - clr_count and press_pulse in the same cycle sets it to 1; the press is not lost.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.
- Internal counter widths come from $clog2 of the parameters. There is no overflow in db_cnt.

Test Plan:
Use N_CH=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, CNT_W=8.
1. Reset: hold rst 3 cycles with button=2'b11 -> all outputs 0 during reset; after release, press_pulse[1:0]=11 exactly 1+1+4 edges later.
2. Bounce rejection: button[0] toggles 1,0,1,0 with pulses of 1-3 clocks -> btn_level[0] stays 0, no pulses, press_count[7:0]=0.
3. Clean press/release: button[0]=1 for 20 clocks, then 0:
   - press_pulse[0] once, level latency as specified
   - long_pulse[0] once, 10 cycles after press_pulse
   - release_pulse[0] once
   - press_count[7:0]=1
4. Glitch during hold: while held, button[0] low for 2 clocks -> no release, long_pulse still fires once at the original timing.
5. Wrap and clear:
   - 256 clean presses on ch1 -> press_count[15:8]=0.
   - Then assert clr_count coincident with a press_pulse -> count=1, ch0 count independently cleared to 0.
6. Reset mid-debounce: rst pulsed while ch0 is in ARM_HI with db_cnt=3 -> level stays 0, no pulse. The debounce restarts from zero after rst deasserts.
